// File: rtl/fifo_reader.sv
// Read-side master for the push/pull FIFO: pulls a commanded burst of words and
// streams them out on valid/ready through a 2-entry skid buffer, tagging the last word.
module fifo_reader #(
  parameter int BUSW = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fifo_empty,
  input  logic [BUSW-1:0] fifo_dataout,
  output logic            fifo_pull,
  input  logic            start,
  input  logic [CNTW-1:0] burst_len,
  output logic            busy,
  output logic            done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BUSW-1:0] out_data,
  output logic            out_last,
  output logic [CNTW-1:0] words_sent
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [CNTW-1:0] remaining;
  logic [1:0]      count;
  logic [BUSW-1:0] head_data;
  logic [BUSW-1:0] tail_data;
  logic            head_last;
  logic            tail_last;
  logic            pop;
  logic            take_last;

  // Stream handshake: a word moves when out_valid && out_ready at a rising edge;
  // while out_valid=1 and out_ready=0 the head word is held unchanged.
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign take_last = (remaining == ONE);

  // A pull into a full buffer is allowed only when the head leaves on the same edge.
  assign fifo_pull = (state == RUN) && !fifo_empty && (remaining != '0) &&
                     ((count < 2'd2) || pop);

  assign out_data = head_data;
  assign out_last = head_last && out_valid;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= burst_len;
            words_sent <= '0;
            state      <= (burst_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (fifo_pull) begin
            remaining <= remaining - ONE;
            if (take_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (pop) words_sent <= words_sent + ONE;
    end
  end

  // Two-entry skid buffer; the head entry always drives the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({fifo_pull, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= fifo_dataout;
            head_last <= take_last;
          end else begin
            tail_data <= fifo_dataout;
            tail_last <= take_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= fifo_dataout;
            head_last <= take_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= fifo_dataout;
            tail_last <= take_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural show-ahead FIFO, ready pattern driver,
// scoreboard on stream handshakes, table of bursts plus hand-written corner cases.
module tb_fifo_reader;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [31:0] fifo_dataout;
  logic        fifo_pull;
  logic        start;
  logic [15:0] burst_len;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] words_sent;

  fifo_reader #(.BUSW(32), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout), .fifo_pull(fifo_pull),
    .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .words_sent(words_sent)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO model ----------------
  logic [31:0] mem [0:255];
  int rd_ptr;
  int wr_ptr;
  int exp_ptr;

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_dataout = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_pull && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  function automatic logic [31:0] data_of(int k);
    if (k < 8) return 32'(k + 16);
    return 32'hA5A5_0000 ^ (32'(k) * 32'h0101_0101);
  endfunction

  // ---------------- ready driver ----------------
  int ready_mode;  // 0: always 1, 1: pattern 1,0,0, 2: random, 3: always 0
  int tick;
  always @(posedge clk) begin
    #2;
    tick++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (tick % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int errors;
  int checks;
  int hs_cnt, last_cnt, done_cnt, pull_cnt;
  int outstanding;
  logic prev_stall;
  logic prev_last;
  logic [31:0] prev_data;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (fifo_pull) begin
        pull_cnt++;
        chk("pull_not_empty", 64'(fifo_empty), 64'd0);
      end
      outstanding = outstanding + (fifo_pull ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (fifo_pull) chk("outstanding_le2", 64'(outstanding <= 2), 64'd1);
      if (prev_stall)
        chk("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev_last, prev_data}));
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (out_last) last_cnt++;
        chk("exp_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_last  = out_last;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word();
    mem[wr_ptr] = data_of(wr_ptr);
    wr_ptr++;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) push_word();
  endtask

  task automatic clear_counters();
    hs_cnt = 0; last_cnt = 0; done_cnt = 0; pull_cnt = 0;
  endtask

  task automatic issue(input int len, input bit accepted);
    step();
    start     = 1'b1;
    burst_len = 16'(len);
    if (accepted) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), data_of(exp_ptr + i)});
      exp_ptr += len;
    end
    step();
    start     = 1'b0;
    burst_len = '0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_not_busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pull"},  64'(fifo_pull),  64'd0);
    chk({tag, "_busy"},  64'(busy),       64'd0);
    chk({tag, "_done"},  64'(done),       64'd0);
    chk({tag, "_valid"}, 64'(out_valid),  64'd0);
    chk({tag, "_data"},  64'(out_data),   64'd0);
    chk({tag, "_last"},  64'(out_last),   64'd0);
    chk({tag, "_sent"},  64'(words_sent), 64'd0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    int len;
    int mode;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{len: 8,  mode: 1};
    vecs[1] = '{len: 1,  mode: 0};
    vecs[2] = '{len: 5,  mode: 2};
    vecs[3] = '{len: 3,  mode: 2};
    vecs[4] = '{len: 0,  mode: 0};
    vecs[5] = '{len: 16, mode: 2};

    rst_n = 1'b0; start = 1'b0; burst_len = '0; ready_mode = 0;
    #12;
    check_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // Back-to-back burst of 8 with a ready consumer: cycle-exact timing.
    preload(8);
    clear_counters();
    issue(8, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t1_pull_%0d", k),  64'(fifo_pull), 64'(k <= 7));
      chk($sformatf("t1_valid_%0d", k), 64'(out_valid), 64'(k >= 1 && k <= 8));
      chk($sformatf("t1_busy_%0d", k),  64'(busy),      64'(k <= 8));
      chk($sformatf("t1_done_%0d", k),  64'(done),      64'(k == 9));
    end
    chk("t1_words_sent", 64'(words_sent), 64'd8);
    @(negedge clk);
    chk("t1_done_gone", 64'(done), 64'd0);
    chk("t1_last_cnt", 64'(last_cnt), 64'd1);
    chk("t1_exp_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length burst.
    clear_counters();
    issue(0, 1'b1);
    @(negedge clk);
    chk("z_done", 64'(done), 64'd1);
    chk("z_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("z_done_gone", 64'(done), 64'd0);
    chk("z_sent", 64'(words_sent), 64'd0);
    chk("z_pulls", 64'(pull_cnt), 64'd0);
    chk("z_hs", 64'(hs_cnt), 64'd0);

    // Table of bursts under different ready patterns.
    for (int v = 0; v < 6; v++) begin
      ready_mode = vecs[v].mode;
      preload(vecs[v].len);
      clear_counters();
      issue(vecs[v].len, 1'b1);
      wait_done(40 + 8 * vecs[v].len);
      chk($sformatf("v%0d_sent", v), 64'(words_sent), 64'(vecs[v].len));
      chk($sformatf("v%0d_hs", v), 64'(hs_cnt), 64'(vecs[v].len));
      chk($sformatf("v%0d_last", v), 64'(last_cnt), 64'(vecs[v].len != 0));
      chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d_exp_empty", v), 64'(exp_q.size()), 64'd0);
    end

    // FIFO runs dry mid-burst, then refills.
    ready_mode = 0;
    step();
    preload(3);
    clear_counters();
    issue(5, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("dry_busy", 64'(busy), 64'd1);
      chk("dry_no_done", 64'(done), 64'd0);
    end
    chk("dry_three_out", 64'(hs_cnt), 64'd3);
    step(); push_word();
    step(); push_word();
    wait_done(40);
    chk("dry_sent", 64'(words_sent), 64'd5);
    chk("dry_last", 64'(last_cnt), 64'd1);
    chk("dry_exp_empty", 64'(exp_q.size()), 64'd0);

    // Start during RUN is ignored; extra FIFO words must stay untouched.
    ready_mode = 1;
    step();
    preload(7);
    clear_counters();
    issue(4, 1'b1);
    issue(3, 1'b0);
    wait_done(80);
    chk("ign_hs", 64'(hs_cnt), 64'd4);
    chk("ign_sent", 64'(words_sent), 64'd4);
    chk("ign_last", 64'(last_cnt), 64'd1);
    pull_cnt = 0;
    repeat (8) step();
    chk("ign_no_pulls", 64'(pull_cnt), 64'd0);
    chk("ign_fifo_left", 64'(wr_ptr - rd_ptr), 64'd3);
    ready_mode = 0;
    step();
    clear_counters();
    issue(3, 1'b1);
    wait_done(30);
    chk("ign_flush_sent", 64'(words_sent), 64'd3);

    // Reset with two words parked in the skid buffer.
    ready_mode = 3;
    step();
    preload(6);
    clear_counters();
    issue(6, 1'b1);
    repeat (5) @(negedge clk);
    chk("rst_buffered_valid", 64'(out_valid), 64'd1);
    chk("rst_buffered_pulls", 64'(pull_cnt), 64'd2);
    chk("rst_full_no_pull", 64'(fifo_pull), 64'd0);
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    exp_ptr = rd_ptr;
    ready_mode = 0;
    step();
    clear_counters();
    issue(2, 1'b1);
    wait_done(30);
    chk("rst_sent", 64'(words_sent), 64'd2);
    chk("rst_hs", 64'(hs_cnt), 64'd2);
    chk("rst_last", 64'(last_cnt), 64'd1);
    chk("rst_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
